// File: rtl/xillybus_loop_fifo.sv
// Stream buffer between a Xillybus write stream and a read stream.
// It adds EOF signalling, flush on close or quiesce, a fill level and sticky error flags.
module xillybus_loop_fifo #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  bus_clk,
  input  logic                  trn_reset_n,
  input  logic                  quiesce,
  input  logic                  user_w_write_wren,
  input  logic [DATA_W-1:0]     user_w_write_data,
  output logic                  user_w_write_full,
  input  logic                  user_w_write_open,
  input  logic                  user_r_read_rden,
  output logic [DATA_W-1:0]     user_r_read_data,
  output logic                  user_r_read_empty,
  output logic                  user_r_read_eof,
  input  logic                  user_r_read_open,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic                  overflow_err,
  output logic                  underflow_err,
  output logic [1:0]            o_dbg_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_DEPTH = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITING = 2'd1,
    S_DRAIN   = 2'd2,
    S_EOF     = 2'd3
  } state_t;

  // Handshake: a write is accepted when wren & ~full, a read when rden & ~empty.
  // Read data is registered and appears one cycle after the accepted rden.
  // If neither strobe is accepted, read data holds its value.
  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_eof;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_ovf;
  logic                  r_udf;
  logic                  r_w_open_d;
  state_t                r_state;

  logic                  w_flush;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_w_rise;
  logic                  w_w_fall;
  logic [DEPTH_LOG2:0]   w_count_nxt;
  state_t                w_state_nxt;

  // A flush discards any transfer presented in the same cycle.
  assign w_flush  = quiesce | (~user_w_write_open & ~user_r_read_open);
  assign w_wr_acc = user_w_write_wren & ~r_full  & ~w_flush;
  assign w_rd_acc = user_r_read_rden  & ~r_empty & ~w_flush;
  assign w_w_rise = user_w_write_open & ~r_w_open_d;
  assign w_w_fall = ~user_w_write_open & r_w_open_d;

  always_comb begin
    w_count_nxt = r_count;
    if (w_flush)
      w_count_nxt = '0;
    else if (w_wr_acc && !w_rd_acc)
      w_count_nxt = r_count + 1'b1;
    else if (w_rd_acc && !w_wr_acc)
      w_count_nxt = r_count - 1'b1;
  end

  // The EOF decision uses the next count so that eof and empty rise on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (w_w_rise) w_state_nxt = S_WRITING;
      S_WRITING: if (w_w_fall) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (w_w_rise)
          w_state_nxt = S_WRITING;
        else if ((w_count_nxt == '0) && user_r_read_open)
          w_state_nxt = S_EOF;
      end
      S_EOF: begin
        if (w_w_rise)
          w_state_nxt = S_WRITING;
        else if (!user_r_read_open)
          w_state_nxt = S_IDLE;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
    if (w_flush)
      w_state_nxt = S_IDLE;
  end

  always_ff @(posedge bus_clk) begin
    if (w_wr_acc)
      r_mem[r_wr_ptr] <= user_w_write_data;
  end

  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_eof      <= 1'b0;
      r_rdata    <= '0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
      r_w_open_d <= 1'b0;
      r_state    <= S_IDLE;
    end else begin
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_rd_acc)
        r_rdata <= r_mem[r_rd_ptr];
      r_count    <= w_count_nxt;
      // Quiesce pins both flags high so the core stops issuing strobes.
      r_full     <= quiesce | (w_count_nxt == C_DEPTH);
      r_empty    <= quiesce | (w_count_nxt == '0);
      r_eof      <= (w_state_nxt == S_EOF) & (w_count_nxt == '0);
      r_state    <= w_state_nxt;
      r_w_open_d <= user_w_write_open;
      // Strobes seen while quiesce forces the flags are not protocol errors.
      if (user_w_write_wren && r_full && !quiesce)
        r_ovf <= 1'b1;
      if (user_r_read_rden && r_empty && !quiesce)
        r_udf <= 1'b1;
    end
  end

  assign user_w_write_full = r_full;
  assign user_r_read_empty = r_empty;
  assign user_r_read_eof   = r_eof;
  assign user_r_read_data  = r_rdata;
  assign fill_level        = r_count;
  assign overflow_err      = r_ovf;
  assign underflow_err     = r_udf;
  assign o_dbg_state       = r_state;

endmodule

// File: doc/xillybus_loop_fifo.md
# xillybus_loop_fifo

Parametrised stream buffer sitting between one Xillybus host-to-FPGA (write) user stream and one FPGA-to-host (read) user stream in the `bus_clk` domain. It generalises the fixed 32-bit loopback pair to configurable width and depth, and adds the following behaviour:
- end-of-file signalling once the writer closes and the buffer drains
- automatic flush when both device files are closed or the link quiesces
- fill-level reporting
- sticky protocol-error flags

## Interface
- DATA_W, 32, stream word width; legal values 8, 16, 32
- DEPTH_LOG2, 9, log2 of buffer depth in words (DEPTH = 2**DEPTH_LOG2); legal 2..12
- bus_clk  in  1  Xillybus bus clock; all logic on rising edge
- trn_reset_n  in  1  reset; asynchronous assert, active-low
- quiesce  in  1  link down / core quiesced; forces flush
- user_w_write_wren  in  1  write strobe from core
- user_w_write_data  in  DATA_W  write word
- user_w_write_full  out  1  buffer full; writes ignored while high
- user_w_write_open  in  1  host write file open
- user_r_read_rden  in  1  read strobe from core
- user_r_read_data  out  DATA_W  read word, valid the cycle after an accepted rden
- user_r_read_empty  out  1  buffer empty
- user_r_read_eof  out  1  end-of-file to host
- user_r_read_open  in  1  host read file open
- fill_level  out  DEPTH_LOG2+1  words currently stored
- overflow_err  out  1  sticky: wren while full
- underflow_err  out  1  sticky: rden while empty

## Operation
- Storage: DEPTH×DATA_W RAM, inferable as block RAM with a synchronous read port.
- Pointers: wr_ptr and rd_ptr, each DEPTH_LOG2 bits, wrapping modulo DEPTH. count is DEPTH_LOG2+1 bits; all three are registered.
- Write accept: wren & ~full. The RAM is written at wr_ptr, then wr_ptr increments.
- Read accept: rden & ~empty. The RAM is read at rd_ptr into the user_r_read_data register, then rd_ptr increments.
- count: +1 on write only, -1 on read only, unchanged on both or neither.
- Status outputs, all registered from next-state count:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - fill_level = count
- Simultaneous write and read while full: the write is rejected (full is high), the read is accepted, and count decrements. Same rule applies at empty: the read is rejected, the write is accepted.
- overflow_err sets on wren & full. underflow_err sets on rden & empty. Both clear only on reset.
- EOF state machine, states IDLE, WRITING, DRAIN, EOF:
  - IDLE -> WRITING when user_w_write_open rises.
  - WRITING -> DRAIN when user_w_write_open falls.
  - DRAIN -> EOF when count reaches 0 and user_r_read_open is high.
  - EOF -> IDLE when user_r_read_open falls.
  - EOF -> WRITING when user_w_write_open rises again.
  - user_r_read_eof = (state == EOF) & empty. EOF is only ever asserted together with empty.
- Flush condition: quiesce high, or both open inputs low (after one full cycle with both low). On flush:
  - pointers and count are zeroed and the FSM goes to IDLE
  - data contents are don't-care
  - error flags are retained
- While quiesce is high, full and empty are both held high, so no transfers occur.

## Timing
- Reset values: full=0, empty=1, eof=0, user_r_read_data=0, fill_level=0, overflow_err=0, underflow_err=0, FSM=IDLE, pointers=0.
- Write in cycle n: empty falls and fill_level updates at edge n+1. A rden in cycle n+1 returns that word at edge n+2.
- Read latency: exactly 1 cycle from accepted rden to data. user_r_read_data holds its value when no read is accepted.
- full rises at the edge following the write that makes count == DEPTH. It falls at the edge following the first accepted read.
- Throughput: one write and one read per cycle sustained; no bubbles at pointer wrap.
- EOF asserts 1 cycle after count reaches 0 in DRAIN, provided read_open is high. It deasserts 1 cycle after read_open falls or write_open rises.
- Flush takes effect at the next edge. A flush coincident with wren/rden discards the transfer.
- Asynchronous reset mid-transfer clears all state immediately; outputs reach reset values with no clock required.

## Test plan
- DATA_W=32, DEPTH_LOG2=4: write 0x00000001..0x00000005, then read 5 -> data returned in order, 1 cycle after each rden; empty=1 and fill_level=0 afterwards.
- Write 16 words -> full=1 and fill_level=16. Write a 17th -> ignored and overflow_err=1. Do simultaneous rden+wren at full -> fill_level=15 and the write is dropped. Continue 40 words at 1 read + 1 write per cycle -> wrap-around is order-correct.
- Open write, write 3 words, close write, keep read open -> eof stays 0 until the 3rd read. Then empty=1 and eof=1 together. Close read -> eof=0.
- DATA_W=8: write 4 bytes, drop both opens for 1 cycle -> fill_level=0 and empty=1. Reopen, write 0xA5, read -> 0xA5.
- Assert quiesce with 6 words stored -> full=1, empty=1, fill_level=0 next edge, wren/rden ignored. Release quiesce -> full=0, empty=1.
- Assert trn_reset_n low mid-burst (asynchronously, between edges) -> all outputs immediately at reset values, including sticky errors=0.
